// File: rtl/vga_timing_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the draw stages.
interface vga_timing_if #(
    parameter int unsigned CNT_W = 11
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        input hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters with registered
// blanking, sync, data-enable and line/frame start strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned H_FP      = 24,
    parameter int unsigned H_SYNC    = 136,
    parameter int unsigned H_BP      = 160,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned V_FP      = 3,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 29,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned CNT_W     = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_en,
    vga_timing_if.master vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             HS_ON    = (HSYNC_POL != 0);
    localparam logic             VS_ON    = (VSYNC_POL != 0);

    if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("vga_timing_gen: H_SYNC and V_SYNC must be at least 1");
    end

    logic [CNT_W-1:0] hcount_q, vcount_q;
    logic [CNT_W-1:0] h_next, v_next;
    logic             hblnk_q, vblnk_q, hsync_q, vsync_q, de_q;
    logic             line_start_q, frame_start_q;
    logic             hblnk_n, vblnk_n, hsync_n, vsync_n;

    always_comb begin
        h_next = hcount_q + 1'b1;
        v_next = vcount_q;
        if (hcount_q == H_LAST) begin
            h_next = '0;
            v_next = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        end
    end

    // Decode from the next counter value so the registered levels line up with
    // the counters they are presented alongside.
    always_comb begin
        hblnk_n = (h_next >= H_ACT);
        vblnk_n = (v_next >= V_ACT);
        hsync_n = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? HS_ON : ~HS_ON;
        vsync_n = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? VS_ON : ~VS_ON;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            hcount_q      <= h_next;
            vcount_q      <= v_next;
            hblnk_q       <= hblnk_n;
            vblnk_q       <= vblnk_n;
            hsync_q       <= hsync_n;
            vsync_q       <= vsync_n;
            de_q          <= ~hblnk_n & ~vblnk_n;
            line_start_q  <= (h_next == '0);
            frame_start_q <= (h_next == '0) && (v_next == '0);
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign vga.hcount      = hcount_q;
    assign vga.vcount      = vcount_q;
    assign vga.hblnk       = hblnk_q;
    assign vga.vblnk       = vblnk_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default mode, a small mode for frame wrap,
// and a tiny active-high-sync mode.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst;
    logic pe_def, pe_mid, pe_ovr;
    int   n_vec = 0;
    int   n_err = 0;
    int   fs_cnt;

    always #5 clk = ~clk;

    vga_timing_if #(.CNT_W(11)) io_def ();
    vga_timing_if #(.CNT_W(11)) io_mid ();
    vga_timing_if #(.CNT_W(11)) io_ovr ();

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_en(pe_def), .vga(io_def)
    );

    // H 16/2/3/3 (total 24), V 10/2/3/2 (total 17), active-low syncs
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2)
    ) u_mid (
        .clk(clk), .rst(rst), .pix_en(pe_mid), .vga(io_mid)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u_ovr (
        .clk(clk), .rst(rst), .pix_en(pe_ovr), .vga(io_ovr)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chkc(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pe_def = 1'b1; pe_mid = 1'b1; pe_ovr = 1'b1;
        tick(3);
        chkc("rst_def_h", io_def.hcount, 11'd0);
        chkc("rst_def_v", io_def.vcount, 11'd0);
        chk1("rst_def_hs", io_def.hsync, 1'b1);
        chk1("rst_def_vs", io_def.vsync, 1'b1);
        chk1("rst_def_de", io_def.de, 1'b0);
        chk1("rst_def_hb", io_def.hblnk, 1'b0);
        chk1("rst_def_ls", io_def.line_start, 1'b0);
        chk1("rst_def_fs", io_def.frame_start, 1'b0);
        chk1("rst_ovr_hs", io_ovr.hsync, 1'b0);
        chk1("rst_ovr_vs", io_ovr.vsync, 1'b0);

        rst = 1'b0;
        tick(1);
        chkc("rel_def_h", io_def.hcount, 11'd1);
        chk1("rel_def_de", io_def.de, 1'b1);
        chk1("rel_def_ls", io_def.line_start, 1'b0);
        chk1("rel_def_fs", io_def.frame_start, 1'b0);
        chkc("rel_mid_h", io_mid.hcount, 11'd1);
        chkc("rel_ovr_h", io_ovr.hcount, 11'd1);
        pe_mid = 1'b0; pe_ovr = 1'b0;

        // Default line timing
        tick(1022);
        chkc("def_h1023", io_def.hcount, 11'd1023);
        chk1("def_de1023", io_def.de, 1'b1);
        tick(1);
        chk1("def_hb1024", io_def.hblnk, 1'b1);
        chk1("def_de1024", io_def.de, 1'b0);
        tick(23);
        chk1("def_hs1047", io_def.hsync, 1'b1);
        tick(1);
        chk1("def_hs1048", io_def.hsync, 1'b0);
        tick(135);
        chkc("def_h1183", io_def.hcount, 11'd1183);
        chk1("def_hs1183", io_def.hsync, 1'b0);
        tick(1);
        chk1("def_hs1184", io_def.hsync, 1'b1);
        tick(159);
        chkc("def_h1343", io_def.hcount, 11'd1343);
        chkc("def_v0", io_def.vcount, 11'd0);
        tick(1);
        chkc("def_wrap_h", io_def.hcount, 11'd0);
        chkc("def_wrap_v", io_def.vcount, 11'd1);
        chk1("def_wrap_ls", io_def.line_start, 1'b1);
        chk1("def_wrap_fs", io_def.frame_start, 1'b0);
        chk1("def_wrap_de", io_def.de, 1'b1);
        tick(1);
        chk1("def_ls_drop", io_def.line_start, 1'b0);

        // Stall at hcount 500
        tick(499);
        chkc("def_h500", io_def.hcount, 11'd500);
        pe_def = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chkc("stall_h", io_def.hcount, 11'd500);
            chkc("stall_v", io_def.vcount, 11'd1);
            chk1("stall_de", io_def.de, 1'b1);
            chk1("stall_hs", io_def.hsync, 1'b1);
            chk1("stall_ls", io_def.line_start, 1'b0);
        end
        pe_def = 1'b1;
        tick(1);
        chkc("resume_h", io_def.hcount, 11'd501);
        pe_def = 1'b0;

        // Small mode: frame wrap, vblank, vsync lines 12..14
        pe_mid = 1'b1;
        tick(22);
        chkc("mid_h23", io_mid.hcount, 11'd23);
        tick(1);
        chkc("mid_l1_v", io_mid.vcount, 11'd1);
        chk1("mid_l1_ls", io_mid.line_start, 1'b1);
        chk1("mid_l1_fs", io_mid.frame_start, 1'b0);
        tick(215);
        chkc("mid_23_9_h", io_mid.hcount, 11'd23);
        chkc("mid_23_9_v", io_mid.vcount, 11'd9);
        chk1("mid_23_9_vb", io_mid.vblnk, 1'b0);
        tick(1);
        chkc("mid_0_10_v", io_mid.vcount, 11'd10);
        chk1("mid_0_10_vb", io_mid.vblnk, 1'b1);
        chk1("mid_0_10_de", io_mid.de, 1'b0);
        tick(47);
        chk1("mid_vs11", io_mid.vsync, 1'b1);
        tick(1);
        chkc("mid_v12", io_mid.vcount, 11'd12);
        chk1("mid_vs12", io_mid.vsync, 1'b0);
        tick(71);
        chk1("mid_vs14", io_mid.vsync, 1'b0);
        tick(1);
        chk1("mid_vs15", io_mid.vsync, 1'b1);
        tick(47);
        chkc("mid_last_h", io_mid.hcount, 11'd23);
        chkc("mid_last_v", io_mid.vcount, 11'd16);
        tick(1);
        chkc("mid_fr_h", io_mid.hcount, 11'd0);
        chkc("mid_fr_v", io_mid.vcount, 11'd0);
        chk1("mid_fr_ls", io_mid.line_start, 1'b1);
        chk1("mid_fr_fs", io_mid.frame_start, 1'b1);
        chk1("mid_fr_de", io_mid.de, 1'b1);
        pe_mid = 1'b0;
        tick(1);
        chkc("mid_hold_h", io_mid.hcount, 11'd0);
        chk1("mid_hold_ls", io_mid.line_start, 1'b0);
        chk1("mid_hold_fs", io_mid.frame_start, 1'b0);
        pe_mid = 1'b1;
        tick(1);
        chkc("mid_res_h", io_mid.hcount, 11'd1);
        chk1("mid_res_fs", io_mid.frame_start, 1'b0);

        // Asynchronous reset mid-frame
        tick(129);
        chkc("mid_pre_h", io_mid.hcount, 11'd10);
        chkc("mid_pre_v", io_mid.vcount, 11'd5);
        #3 rst = 1'b1;
        #1;
        chkc("arst_h", io_mid.hcount, 11'd0);
        chkc("arst_v", io_mid.vcount, 11'd0);
        chk1("arst_de", io_mid.de, 1'b0);
        chk1("arst_hs", io_mid.hsync, 1'b1);
        chk1("arst_vs", io_mid.vsync, 1'b1);
        chkc("arst_def_h", io_def.hcount, 11'd0);
        @(posedge clk);
        #1;
        pe_def = 1'b1; pe_mid = 1'b1; pe_ovr = 1'b1;
        rst = 1'b0;
        tick(1);
        chkc("post_mid_h", io_mid.hcount, 11'd1);
        chkc("post_mid_v", io_mid.vcount, 11'd0);
        chkc("post_def_v", io_def.vcount, 11'd0);
        chk1("post_mid_fs", io_mid.frame_start, 1'b0);
        pe_def = 1'b0; pe_mid = 1'b0;

        // Tiny mode, active-high syncs: hsync 9..10, vsync line 5
        tick(7);
        chkc("ovr_h8", io_ovr.hcount, 11'd8);
        chk1("ovr_hs8", io_ovr.hsync, 1'b0);
        chk1("ovr_hb8", io_ovr.hblnk, 1'b1);
        tick(1);
        chk1("ovr_hs9", io_ovr.hsync, 1'b1);
        tick(1);
        chk1("ovr_hs10", io_ovr.hsync, 1'b1);
        tick(1);
        chk1("ovr_hs11", io_ovr.hsync, 1'b0);
        tick(1);
        chkc("ovr_l1_v", io_ovr.vcount, 11'd1);
        chk1("ovr_l1_ls", io_ovr.line_start, 1'b1);
        tick(48);
        chkc("ovr_v5", io_ovr.vcount, 11'd5);
        chk1("ovr_vs5", io_ovr.vsync, 1'b1);
        chk1("ovr_vb5", io_ovr.vblnk, 1'b1);
        tick(11);
        chk1("ovr_vs5e", io_ovr.vsync, 1'b1);
        tick(1);
        chk1("ovr_vs6", io_ovr.vsync, 1'b0);
        tick(12);
        chkc("ovr_fr_v", io_ovr.vcount, 11'd0);
        chkc("ovr_fr_h", io_ovr.hcount, 11'd0);
        chk1("ovr_fr_fs", io_ovr.frame_start, 1'b1);
        fs_cnt = 0;
        for (int i = 0; i < 168; i++) begin
            tick(1);
            if (io_ovr.frame_start) fs_cnt++;
        end
        chkc("ovr_fs_count", 11'(fs_cnt), 11'd2);
        chk1("ovr_fs_end", io_ovr.frame_start, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
